// File: rtl/ahb_lite_master_if.sv
// Local command/response channel plus the AHB-Lite master-side bus, bundled for ahb_lite_master.
// Commands transfer when cmd_valid & cmd_ready at a rising HCLK; rsp_valid is a single-cycle pulse with no backpressure.
interface ahb_lite_master_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_size;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [3:0]        HPROT;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HREADY, HRDATA, HRESP,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HREADY, HRDATA, HRESP,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA
  );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: local commands become single NONSEQ transfers through an address-phase
// and a data-phase register, with wait states, two-cycle ERROR handling and lane steering.
module ahb_lite_master #(
  parameter int         ADDR_W    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_lite_master_if.master bus,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ERR    = 2'd1,
    ST_CANCEL = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              ap_valid_q, ap_valid_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic [1:0]        ap_size_q, ap_size_d;
  logic              ap_write_q, ap_write_d;
  logic [31:0]       ap_wdata_q, ap_wdata_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [1:0]        dp_size_q, dp_size_d;
  logic [1:0]        dp_addr_lo_q, dp_addr_lo_d;
  logic [31:0]       dp_wdata_q, dp_wdata_d;
  logic              cancel_q, cancel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              err_state;
  logic              cmd_ready;
  logic              accept;
  logic              err_first;
  logic [1:0]        cmd_size_n;
  logic [ADDR_W-1:0] cmd_addr_al;
  logic [31:0]       rd_shifted;
  logic [31:0]       rd_aligned;

  function automatic logic [31:0] lane_rep(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    lane_rep = {4{d[7:0]}};
      2'd1:    lane_rep = {2{d[15:0]}};
      default: lane_rep = d;
    endcase
  endfunction

  // FSM: state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (err_first) state_d = ST_ERR;
      ST_ERR:    if (bus.HREADY) state_d = cancel_q ? ST_CANCEL : ST_RUN;
      ST_CANCEL: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    err_state   = (state_q != ST_RUN);
    cmd_ready   = (~ap_valid_q | bus.HREADY) & ~err_state;
    dbg_state_o = state_q;
  end

  assign accept    = bus.cmd_valid & cmd_ready;
  assign err_first = (state_q == ST_RUN) & dp_valid_q & bus.HRESP & ~bus.HREADY;

  always_comb begin
    cmd_size_n  = (bus.cmd_size == 2'd3) ? 2'd2 : bus.cmd_size;
    cmd_addr_al = bus.cmd_addr;
    if (cmd_size_n == 2'd1)      cmd_addr_al[0]   = 1'b0;
    else if (cmd_size_n == 2'd2) cmd_addr_al[1:0] = 2'b00;
  end

  always_comb begin
    rd_shifted = bus.HRDATA >> {dp_addr_lo_q, 3'b000};
    case (dp_size_q)
      2'd0:    rd_aligned = {24'h0, rd_shifted[7:0]};
      2'd1:    rd_aligned = {16'h0, rd_shifted[15:0]};
      default: rd_aligned = rd_shifted;
    endcase
  end

  always_comb begin
    ap_valid_d   = ap_valid_q;
    ap_addr_d    = ap_addr_q;
    ap_size_d    = ap_size_q;
    ap_write_d   = ap_write_q;
    ap_wdata_d   = ap_wdata_q;
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    dp_size_d    = dp_size_q;
    dp_addr_lo_d = dp_addr_lo_q;
    dp_wdata_d   = dp_wdata_q;
    cancel_d     = cancel_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = 32'h0;
    rsp_err_d    = 1'b0;
    if (err_first) begin
      // First ERROR cycle: a transfer already in address phase is withdrawn and answered later.
      if (ap_valid_q) begin
        ap_valid_d = 1'b0;
        cancel_d   = 1'b1;
      end
    end else if (bus.HREADY) begin
      dp_valid_d = ap_valid_q;
      if (ap_valid_q) begin
        dp_write_d   = ap_write_q;
        dp_size_d    = ap_size_q;
        dp_addr_lo_d = ap_addr_q[1:0];
        dp_wdata_d   = lane_rep(ap_wdata_q, ap_size_q);
      end
      ap_valid_d = accept;
      if (accept) begin
        ap_addr_d  = cmd_addr_al;
        ap_size_d  = cmd_size_n;
        ap_write_d = bus.cmd_write;
        ap_wdata_d = bus.cmd_wdata;
      end
      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = bus.HRESP | (state_q == ST_ERR);
        rsp_rdata_d = (rsp_err_d | dp_write_q) ? 32'h0 : rd_aligned;
      end
    end
    if (state_q == ST_CANCEL) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = 32'h0;
      cancel_d    = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q   <= 1'b0;
      ap_addr_q    <= '0;
      ap_size_q    <= 2'd0;
      ap_write_q   <= 1'b0;
      ap_wdata_q   <= 32'h0;
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_size_q    <= 2'd0;
      dp_addr_lo_q <= 2'd0;
      dp_wdata_q   <= 32'h0;
      cancel_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      ap_valid_q   <= ap_valid_d;
      ap_addr_q    <= ap_addr_d;
      ap_size_q    <= ap_size_d;
      ap_write_q   <= ap_write_d;
      ap_wdata_q   <= ap_wdata_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_size_q    <= dp_size_d;
      dp_addr_lo_q <= dp_addr_lo_d;
      dp_wdata_q   <= dp_wdata_d;
      cancel_q     <= cancel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.HADDR     = ap_addr_q;
  assign bus.HTRANS    = ap_valid_q ? 2'b10 : 2'b00;
  assign bus.HSIZE     = {1'b0, ap_size_q};
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HWRITE    = ap_write_q;
  assign bus.HWDATA    = dp_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
